// File: rtl/cascade_ctrl.sv
// cascade_ctrl: 8259-style cascade controller. Tracks the INTA pulse train,
// drives the cascade address when acting as master and latches the address
// match when acting as slave. It also reports when this device owns the
// vector bytes on the data bus.
// Optional idle watchdog between INTA pulses: define CASCADE_TIMEOUT_EN.
module cascade_ctrl #(
  parameter int unsigned CAS_W       = 3,
  parameter int unsigned MODE_8086   = 1,
  parameter int unsigned TIMEOUT_CYC = 64,
  localparam int unsigned NUM_SLAVES = 2**CAS_W
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  SPEN,
  input  logic                  SNGL,
  input  logic [NUM_SLAVES-1:0] SLAVE_MASK,
  input  logic [CAS_W-1:0]      SLAVE_ID,
  input  logic [CAS_W-1:0]      IRQ_SEL,
  input  logic                  INTA_N,
  inout  wire  [CAS_W-1:0]      CASCADE,
  output logic                  CAS_OE,
  output logic                  ACK,
  output logic                  VEC_EN,
  output logic [1:0]            PULSE_CNT,
  output logic                  BUSY,
  output logic                  SEQ_DONE,
  output logic                  SEQ_ABORT
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_P1,
    S_GAP,
    S_PV,
    S_END
  } state_t;

  state_t             r_state;
  logic               r_inta_q;
  logic               r_spen;
  logic               r_sngl;
  logic               r_mask_bit;
  logic [CAS_W-1:0]   r_slave_id;
  logic [CAS_W-1:0]   r_irq_sel;
  logic               r_cas_oe;
  logic               r_ack;
  logic               r_vec_en;
  logic [1:0]         r_pulse_cnt;
  logic               r_busy;
  logic               r_seq_done;

  logic               w_fall;
  logic               w_rise;
  logic               w_owns_vec;
  logic               w_more_pulses;

  // inta_q resets to 0, so a pulse already low when reset is released never
  // produces a fall.
  assign w_fall = r_inta_q & ~INTA_N;
  assign w_rise = ~r_inta_q & INTA_N;

  // Single mode, a master whose IR has no slave, or a slave that matched its
  // address: this device owns the vector bytes.
  assign w_owns_vec = r_sngl | (r_spen & ~r_mask_bit) | (~r_spen & r_ack);

  // In 8080 mode, pulse 2 is followed by a third (vector) pulse.
  assign w_more_pulses = (MODE_8086 == 0) && (r_pulse_cnt == 2'd2);

`ifdef CASCADE_TIMEOUT_EN
  localparam int unsigned    TO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] r_gap_cnt;
  logic            r_seq_abort;

  assign SEQ_ABORT = r_seq_abort;
`else
  logic w_unused_timeout;

  // Timeout depth only matters when the watchdog is compiled in.
  assign w_unused_timeout = (TIMEOUT_CYC != 0);
  assign SEQ_ABORT        = 1'b0;
`endif

  // Sequence FSM: latches the sequence context at pulse-1 fall and owns all
  // registered outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= S_IDLE;
      r_inta_q    <= 1'b0;
      r_spen      <= 1'b0;
      r_sngl      <= 1'b0;
      r_mask_bit  <= 1'b0;
      r_slave_id  <= '0;
      r_irq_sel   <= '0;
      r_cas_oe    <= 1'b0;
      r_ack       <= 1'b0;
      r_vec_en    <= 1'b0;
      r_pulse_cnt <= '0;
      r_busy      <= 1'b0;
      r_seq_done  <= 1'b0;
`ifdef CASCADE_TIMEOUT_EN
      r_gap_cnt   <= '0;
      r_seq_abort <= 1'b0;
`endif
    end else begin
      r_inta_q   <= INTA_N;
      r_seq_done <= 1'b0;
`ifdef CASCADE_TIMEOUT_EN
      r_seq_abort <= 1'b0;
`endif
      case (r_state)
        // END behaves like IDLE except that it has just cleared the outputs,
        // so a fall seen here starts the next sequence without losing it.
        S_IDLE, S_END: begin
          if (w_fall) begin
            r_state     <= S_P1;
            r_spen      <= SPEN;
            r_sngl      <= SNGL;
            r_mask_bit  <= SLAVE_MASK[IRQ_SEL];
            r_slave_id  <= SLAVE_ID;
            r_irq_sel   <= IRQ_SEL;
            r_cas_oe    <= SPEN & ~SNGL & SLAVE_MASK[IRQ_SEL];
            r_ack       <= 1'b0;
            r_vec_en    <= 1'b0;
            r_pulse_cnt <= 2'd1;
            r_busy      <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_P1: begin
          if (w_rise) begin
            r_state <= S_GAP;
            r_ack   <= ~r_spen & ~r_sngl & (CASCADE == r_slave_id);
`ifdef CASCADE_TIMEOUT_EN
            r_gap_cnt <= '0;
`endif
          end
        end
        S_GAP: begin
          if (w_fall) begin
            r_state     <= S_PV;
            r_pulse_cnt <= r_pulse_cnt + 2'd1;
            r_vec_en    <= w_owns_vec;
`ifdef CASCADE_TIMEOUT_EN
            r_gap_cnt   <= '0;
          end else if (r_gap_cnt == TO_LAST) begin
            r_state     <= S_IDLE;
            r_seq_abort <= 1'b1;
            r_cas_oe    <= 1'b0;
            r_ack       <= 1'b0;
            r_vec_en    <= 1'b0;
            r_busy      <= 1'b0;
            r_pulse_cnt <= '0;
          end else begin
            r_gap_cnt <= r_gap_cnt + TO_W'(1);
`endif
          end
        end
        S_PV: begin
          if (w_rise) begin
            r_vec_en <= 1'b0;
            if (w_more_pulses) begin
              r_state <= S_GAP;
`ifdef CASCADE_TIMEOUT_EN
              r_gap_cnt <= '0;
`endif
            end else begin
              r_state     <= S_END;
              r_seq_done  <= 1'b1;
              r_cas_oe    <= 1'b0;
              r_ack       <= 1'b0;
              r_busy      <= 1'b0;
              r_pulse_cnt <= '0;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign CASCADE   = r_cas_oe ? r_irq_sel : 'z;
  assign CAS_OE    = r_cas_oe;
  assign ACK       = r_ack;
  assign VEC_EN    = r_vec_en;
  assign PULSE_CNT = r_pulse_cnt;
  assign BUSY      = r_busy;
  assign SEQ_DONE  = r_seq_done;

endmodule

// File: tb/tb_cascade_ctrl.sv
// Testbench for cascade_ctrl: two instances (dut0 in 8086 mode, dut1 in
// 8080 mode). The stimulus pushes one expected sequence record per INTA
// train; a negedge monitor checks each sequence and pops at its end.
module tb_cascade_ctrl;
  localparam int TO = 8;

  typedef struct {
    bit         cas_oe;
    logic [2:0] cas_val;
    bit         ack;
    int         ack_from;
    int         vec_cnt;
    int         hist;
    int         start_cyc;
    int         end_cyc;
    bit         abort;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       spen_i[2], sngl_i[2], inta_n[2], tb_drv[2];
  logic [7:0] mask_i[2];
  logic [2:0] id_i[2], sel_i[2], tb_cas[2], mon_cas[2];
  logic       o_cas_oe[2], o_ack[2], o_vec[2], o_busy[2], o_done[2], o_abort[2];
  logic [1:0] o_pc[2];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit mon_off[2];

  exp_t q0[$];
  exp_t q1[$];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    wire [2:0] cas_bus;
    assign cas_bus    = tb_drv[g] ? tb_cas[g] : 3'bzzz;
    assign mon_cas[g] = cas_bus;
    cascade_ctrl #(
      .CAS_W      (3),
      .MODE_8086  ((g == 0) ? 1 : 0),
      .TIMEOUT_CYC(TO)
    ) u_dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .SPEN      (spen_i[g]),
      .SNGL      (sngl_i[g]),
      .SLAVE_MASK(mask_i[g]),
      .SLAVE_ID  (id_i[g]),
      .IRQ_SEL   (sel_i[g]),
      .INTA_N    (inta_n[g]),
      .CASCADE   (cas_bus),
      .CAS_OE    (o_cas_oe[g]),
      .ACK       (o_ack[g]),
      .VEC_EN    (o_vec[g]),
      .PULSE_CNT (o_pc[g]),
      .BUSY      (o_busy[g]),
      .SEQ_DONE  (o_done[g]),
      .SEQ_ABORT (o_abort[g])
    );
  end

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int sb_size(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic exp_t sb_front(input int k);
    return (k == 0) ? q0[0] : q1[0];
  endfunction

  function automatic void sb_pop(input int k);
    if (k == 0) void'(q0.pop_front());
    else        void'(q1.pop_front());
  endfunction

  function automatic void sb_push(input int k, input exp_t e);
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endfunction

  // ---------------- monitor ----------------
  bit   in_seq[2], have_exp[2], v_prev[2];
  bit   bad_oe[2], bad_cas[2], bad_vec[2], bad_ack[2];
  int   hist[2], pc_prev[2], vcnt[2];
  exp_t cur[2];

  always @(negedge CLK) begin
    for (int k = 0; k < 2; k++) begin
      if (!RST_N || mon_off[k]) begin
        in_seq[k] = 1'b0;
      end else begin
        if (!in_seq[k] && o_busy[k]) begin
          in_seq[k]   = 1'b1;
          have_exp[k] = (sb_size(k) > 0);
          chk($sformatf("dut%0d_expected_seq", k), int'(have_exp[k]), 1);
          cur[k] = have_exp[k] ? sb_front(k) : '{default: 0};
          chk($sformatf("dut%0d_start_cyc", k), cyc, cur[k].start_cyc);
          hist[k] = 0; pc_prev[k] = 0; vcnt[k] = 0; v_prev[k] = 1'b0;
          bad_oe[k] = 1'b0; bad_cas[k] = 1'b0; bad_vec[k] = 1'b0; bad_ack[k] = 1'b0;
        end else if (!in_seq[k] && (o_done[k] || o_abort[k])) begin
          chk($sformatf("dut%0d_stray_end", k), 1, 0);
        end
        if (in_seq[k]) begin
          if (o_busy[k]) begin
            if (int'(o_pc[k]) != pc_prev[k] && o_pc[k] != 2'd0) hist[k] = hist[k] * 4 + int'(o_pc[k]);
            pc_prev[k] = int'(o_pc[k]);
            if (o_vec[k] && !v_prev[k]) vcnt[k]++;
            v_prev[k] = o_vec[k];
            if (o_vec[k] && o_pc[k] < 2'd2) bad_vec[k] = 1'b1;
            if (o_cas_oe[k] !== cur[k].cas_oe) bad_oe[k] = 1'b1;
            if (o_cas_oe[k] && mon_cas[k] !== cur[k].cas_val) bad_cas[k] = 1'b1;
            if (o_ack[k] !== (cur[k].ack && cyc >= cur[k].ack_from)) bad_ack[k] = 1'b1;
          end else begin
            chk($sformatf("dut%0d_end_cyc", k), cyc, cur[k].end_cyc);
            chk($sformatf("dut%0d_end_flags", k), int'({o_done[k], o_abort[k]}),
                cur[k].abort ? 1 : 2);
            chk($sformatf("dut%0d_pulse_hist", k), hist[k], cur[k].hist);
            chk($sformatf("dut%0d_vec_pulses", k), vcnt[k], cur[k].vec_cnt);
            chk($sformatf("dut%0d_vec_window", k), int'(bad_vec[k]), 0);
            chk($sformatf("dut%0d_cas_oe_track", k), int'(bad_oe[k]), 0);
            chk($sformatf("dut%0d_cas_value", k), int'(bad_cas[k]), 0);
            chk($sformatf("dut%0d_ack_track", k), int'(bad_ack[k]), 0);
            chk($sformatf("dut%0d_end_clear", k),
                int'({o_cas_oe[k], o_ack[k], o_vec[k], o_pc[k]}), 0);
            if (have_exp[k]) sb_pop(k);
            in_seq[k] = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic run_seq(input int k, input bit spen, input bit sngl,
                         input logic [7:0] mask, input logic [2:0] id,
                         input logic [2:0] sel, input logic [2:0] cas,
                         input bit rnd, input bit withhold);
    exp_t e;
    int   n, t, rise;
    int   lo[3], hi[3];
    bit   owns;
    n = withhold ? 1 : ((k == 0) ? 2 : 3);
    for (int p = 0; p < 3; p++) begin
      lo[p] = rnd ? int'($urandom_range(4, 2)) : 3;
      hi[p] = rnd ? int'($urandom_range(4, 2)) : 3;
    end
    spen_i[k] = spen; sngl_i[k] = sngl; mask_i[k] = mask;
    id_i[k] = id; sel_i[k] = sel;
    tb_drv[k] = !spen; tb_cas[k] = cas; inta_n[k] = 1'b1;

    // Reference rules: what this device should do for this context.
    e.cas_oe  = spen && !sngl && mask[sel];
    e.cas_val = sel;
    e.ack     = !spen && !sngl && (cas == id);
    owns      = sngl || (spen && !mask[sel]) || e.ack;
    e.vec_cnt = owns ? n - 1 : 0;
    e.hist = 0;
    for (int p = 1; p <= n; p++) e.hist = e.hist * 4 + p;
    t = cyc + 2;
    e.start_cyc = t + 1;
    e.ack_from  = t + lo[0] + 1;
    rise = t;
    for (int p = 0; p < n; p++) begin
      rise = t + lo[p];
      t    = rise + hi[p];
    end
    e.abort   = withhold;
    e.end_cyc = withhold ? rise + TO + 1 : rise + 1;
    sb_push(k, e);

    repeat (2) step();
    for (int p = 0; p < n; p++) begin
      inta_n[k] = 1'b0;
      if (rnd) begin
        step();
        spen_i[k] = 1'($urandom); sngl_i[k] = 1'($urandom);
        mask_i[k] = 8'($urandom); sel_i[k]  = 3'($urandom);
        id_i[k]   = 3'($urandom);
        repeat (lo[p] - 1) step();
      end else begin
        repeat (lo[p]) step();
      end
      inta_n[k] = 1'b1;
      repeat (hi[p]) step();
    end
    if (withhold) repeat (TO + 2) step();
    else          step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      spen_i[k] = 1'b0; sngl_i[k] = 1'b0; inta_n[k] = 1'b1; tb_drv[k] = 1'b0;
      mask_i[k] = '0; id_i[k] = '0; sel_i[k] = '0; tb_cas[k] = '0;
      mon_off[k] = 1'b0;
    end
    #3;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("dut%0d_rst_cas_oe", k), int'(o_cas_oe[k]), 0);
      chk($sformatf("dut%0d_rst_ack", k),    int'(o_ack[k]), 0);
      chk($sformatf("dut%0d_rst_vec", k),    int'(o_vec[k]), 0);
      chk($sformatf("dut%0d_rst_pcnt", k),   int'(o_pc[k]), 0);
      chk($sformatf("dut%0d_rst_busy", k),   int'(o_busy[k]), 0);
      chk($sformatf("dut%0d_rst_done", k),   int'(o_done[k]), 0);
      chk($sformatf("dut%0d_rst_abort", k),  int'(o_abort[k]), 0);
    end
    repeat (2) step();
    RST_N = 1'b1;
    step();

    // Directed: master cascaded (8086), matching slave (8080), mismatching
    // slave, single mode with a full mask.
    run_seq(0, 1'b1, 1'b0, 8'h04, 3'd0, 3'd2, 3'd0, 1'b0, 1'b0);
    run_seq(1, 1'b0, 1'b0, 8'h00, 3'd2, 3'd0, 3'd2, 1'b0, 1'b0);
    run_seq(1, 1'b0, 1'b0, 8'h00, 3'd5, 3'd0, 3'd2, 1'b0, 1'b0);
    run_seq(0, 1'b0, 1'b0, 8'h00, 3'd5, 3'd0, 3'd2, 1'b0, 1'b0);
    run_seq(0, 1'b1, 1'b1, 8'hFF, 3'd0, 3'd3, 3'd0, 1'b0, 1'b0);
    run_seq(1, 1'b1, 1'b0, 8'hFB, 3'd0, 3'd2, 3'd0, 1'b0, 1'b0);

    // Async reset during pulse 2: dut0 cascaded master, dut1 single mode.
    mon_off[0] = 1'b1; mon_off[1] = 1'b1;
    spen_i[0] = 1'b1; sngl_i[0] = 1'b0; mask_i[0] = 8'h04; sel_i[0] = 3'd2;
    spen_i[1] = 1'b1; sngl_i[1] = 1'b1; mask_i[1] = 8'hFF; sel_i[1] = 3'd0;
    tb_drv[0] = 1'b0; tb_drv[1] = 1'b0;
    repeat (2) step();
    inta_n[0] = 1'b0; inta_n[1] = 1'b0; repeat (3) step();
    inta_n[0] = 1'b1; inta_n[1] = 1'b1; repeat (2) step();
    inta_n[0] = 1'b0; inta_n[1] = 1'b0; repeat (2) step();
    chk("rst_pre_cas_oe", int'(o_cas_oe[0]), 1);
    chk("rst_pre_vec",    int'(o_vec[1]), 1);
    chk("rst_pre_pcnt",   int'(o_pc[0]), 2);
    #2;
    RST_N = 1'b0;
    #1;
    chk("rst_async_cas_oe", int'(o_cas_oe[0]), 0);
    chk("rst_async_vec",    int'(o_vec[1]), 0);
    chk("rst_async_busy0",  int'(o_busy[0]), 0);
    chk("rst_async_busy1",  int'(o_busy[1]), 0);
    chk("rst_async_pcnt",   int'(o_pc[0]), 0);

    // INTA held low across reset release must not start a sequence.
    inta_n[1] = 1'b1;
    repeat (2) step();
    RST_N = 1'b1;
    repeat (5) step();
    chk("inta_low_release_busy", int'(o_busy[0]), 0);
    chk("inta_low_release_pcnt", int'(o_pc[0]), 0);
    mon_off[0] = 1'b0; mon_off[1] = 1'b0;
    run_seq(0, 1'b1, 1'b0, 8'h04, 3'd0, 3'd2, 3'd0, 1'b0, 1'b0);

`ifdef CASCADE_TIMEOUT_EN
    run_seq(1, 1'b1, 1'b0, 8'h04, 3'd0, 3'd2, 3'd0, 1'b0, 1'b1);
    run_seq(0, 1'b1, 1'b0, 8'h10, 3'd0, 3'd4, 3'd0, 1'b0, 1'b1);
`endif

    // Randomized contexts, widths and mid-sequence input churn.
    for (int i = 0; i < 40; i++) begin
      int         k;
      logic [2:0] id, cas;
      k   = int'($urandom_range(1, 0));
      id  = 3'($urandom);
      cas = ($urandom_range(1, 0) == 1) ? id : 3'($urandom);
      run_seq(k, 1'($urandom), ($urandom_range(3, 0) == 0), 8'($urandom),
              id, 3'($urandom), cas, 1'b1, 1'b0);
    end

    repeat (5) step();
    chk("dut0_queue_empty", q0.size(), 0);
    chk("dut1_queue_empty", q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
